lcd1604_responder: RTL and testbench

Synthesizable HD44780-compatible display responder for the 16x4 character LCD bus (rs, rw, e, 8-bit data). It sits on the far end of the LCD controller's bus, either as a bench/in-FPGA display model or feeding a video text overlay. It decodes commands and data writes into an 80-byte DDRAM with cursor, entry-mode and busy-flag semantics, and answers status and data reads.

---
 rtl/lcd1604_pkg.sv | 66 ++++++
 rtl/lcd_e_sync.sv | 39 +++
 rtl/lcd1604_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_lcd1604_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd1604_pkg.sv
// Shared opcodes, address map, FSM states and address arithmetic
// for the HD44780-compatible 16x4 LCD responder.
package lcd1604_pkg;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_DISP_CUR = 8'h0E;
  localparam logic [7:0] CMD_FUNC     = 8'h38;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE2_BASE = 7'h10;
  localparam logic [6:0] LINE3_BASE = 7'h50;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR,
    ST_BUSY
  } state_t;

  // Step the address counter inside the two 40-cell windows.
  function automatic logic [6:0] addr_step(
    input logic [6:0] a,
    input logic       inc
  );
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // Fold an arbitrary address into its line: bit 6 picks the base,
  // the low six bits are reduced mod 40 (one subtract suffices).
  function automatic logic [6:0] addr_fix(input logic [6:0] a);
    logic [5:0] off;
    off = a[5:0];
    if (off >= 6'd40) off = off - 6'd40;
    return {a[6], off};
  endfunction

  // Valid address to linear DDRAM cell index 0..79.
  function automatic logic [6:0] addr_index(input logic [6:0] a);
    return a[6] ? {1'b0, a[5:0]} + 7'd40 : {1'b0, a[5:0]};
  endfunction

  function automatic logic [5:0] shift_step(
    input logic [5:0] s,
    input logic       right
  );
    logic [5:0] r;
    if (right) r = (s == 6'd39) ? 6'd0 : s + 6'd1;
    else       r = (s == 6'd0) ? 6'd39 : s - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_e_sync.sv
// 2-flop synchronizer for the LCD bus plus E rise/fall pulses.
// Ports: clk, reset (sync, active-low), raw bus in; synced bus, rise, fall out.
module lcd_e_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  input  logic [7:0] data,
  output logic       e_s,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] data_s,
  output logic       rise,
  output logic       fall
);

  logic [10:0] s1;
  logic [10:0] s2;
  logic        e_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1  <= '0;
      s2  <= '0;
      e_d <= 1'b0;
    end else begin
      s1  <= {e, rs, rw, data};
      s2  <= s1;
      e_d <= s2[10];
    end
  end

  // Fields come from the same stage as E, so they line up with the pulses.
  assign {e_s, rs_s, rw_s, data_s} = s2;
  assign rise = s2[10] & ~e_d;
  assign fall = ~s2[10] & e_d;

endmodule

// File: rtl/lcd1604_responder.sv
// HD44780-compatible 16x4 LCD bus responder: 80-byte DDRAM, cursor,
// entry mode, busy flag, status/data reads and a debug read port.
// Ports: clk, reset (sync, active-low); lcd_rs/rw/e/data_i bus in;
// lcd_data_o/oe bus out; busy, display_on, cursor_on, blink_on, incr,
// ddram_addr, cmd_err status; dbg_addr -> dbg_char (1-cycle latency).
// Build option LCD1604_RESPONDER_SHIFT_EN adds disp_shift[5:0].
module lcd1604_responder
  import lcd1604_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500,
  parameter int DDRAM_DEPTH  = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       incr,
  output logic [6:0] ddram_addr,
  output logic       cmd_err,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char
`ifdef LCD1604_RESPONDER_SHIFT_EN
  ,
  output logic [5:0] disp_shift
`endif
);

  // Clear must leave room for the 80-cell sweep plus one BUSY cycle.
  localparam int CLR_TOTAL =
    (CLEAR_CYCLES > 82) ? CLEAR_CYCLES : 82;
  localparam logic [31:0] BUSY_LD = 32'(BUSY_CYCLES - 2);
  localparam logic [31:0] CLR_LD  = 32'(CLR_TOTAL - 2);
  localparam logic [6:0]  SW_LAST = 7'(DDRAM_DEPTH - 1);

  logic       s_e, s_rs, s_rw, s_rise, s_fall;
  logic [7:0] s_data;

  lcd_e_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rs     (lcd_rs),
    .rw     (lcd_rw),
    .e      (lcd_e),
    .data   (lcd_data_i),
    .e_s    (s_e),
    .rs_s   (s_rs),
    .rw_s   (s_rw),
    .data_s (s_data),
    .rise   (s_rise),
    .fall   (s_fall)
  );

  state_t      state, state_n;
  logic [31:0] cnt;
  logic [6:0]  sweep;
  logic        boot;
  logic        c_rs;
  logic [7:0]  c_data;
  logic        accept_wr, accept_rd, drop;
  logic        sweep_last;
`ifdef LCD1604_RESPONDER_SHIFT_EN
  logic        ent_s;
`endif

  logic [7:0]  mem [DDRAM_DEPTH];
  logic        mem_we;
  logic [6:0]  mem_wa;
  logic [7:0]  mem_wd;

  assign sweep_last  = (sweep == SW_LAST);
  assign busy        = (state != ST_IDLE);
  assign lcd_data_oe = s_e & s_rw;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_CLEAR;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    drop      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (s_fall) begin
          if (!s_rw) begin
            accept_wr = 1'b1;
            state_n   = ST_EXEC;
          end else if (s_rs) begin
            accept_rd = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (!c_rs && c_data == CMD_CLEAR) state_n = ST_CLEAR;
        else                              state_n = ST_BUSY;
      end
      ST_CLEAR: begin
        // The power-on sweep ends straight in IDLE.
        if (sweep_last) state_n = boot ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt == '0) state_n = ST_IDLE;
      end
      default: state_n = ST_CLEAR;
    endcase
    // Status reads are always answered; anything else is lost.
    if (busy && s_fall && (!s_rw || s_rs)) drop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      sweep      <= '0;
      boot       <= 1'b1;
      c_rs       <= 1'b0;
      c_data     <= '0;
      ddram_addr <= '0;
      incr       <= 1'b1;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      cmd_err    <= 1'b0;
      lcd_data_o <= '0;
`ifdef LCD1604_RESPONDER_SHIFT_EN
      ent_s      <= 1'b0;
      disp_shift <= '0;
`endif
    end else begin
      cmd_err <= drop;
      if (accept_wr) begin
        c_rs   <= s_rs;
        c_data <= s_data;
      end
      if (s_rise) begin
        lcd_data_o <= s_rs ? mem[addr_index(ddram_addr)]
                           : {busy, ddram_addr};
      end
      unique case (state)
        ST_IDLE: begin
          if (accept_rd) ddram_addr <= addr_step(ddram_addr, incr);
        end
        ST_EXEC: begin
          cnt <= BUSY_LD;
          if (c_rs) begin
            ddram_addr <= addr_step(ddram_addr, incr);
`ifdef LCD1604_RESPONDER_SHIFT_EN
            if (ent_s) disp_shift <= shift_step(disp_shift, !incr);
`endif
          end else begin
            unique case (1'b1)
              c_data[7]: ddram_addr <= addr_fix(c_data[6:0]);
              c_data[7:6] == 2'b01,
              c_data[7:5] == 3'b001: ;
              c_data[7:4] == 4'b0001: begin
                if (!c_data[3])
                  ddram_addr <= addr_step(ddram_addr, c_data[2]);
`ifdef LCD1604_RESPONDER_SHIFT_EN
                else
                  disp_shift <= shift_step(disp_shift, c_data[2]);
`endif
              end
              c_data[7:3] == 5'b00001: begin
                display_on <= c_data[2];
                cursor_on  <= c_data[1];
                blink_on   <= c_data[0];
              end
              c_data[7:2] == 6'b000001: begin
                incr  <= c_data[1];
`ifdef LCD1604_RESPONDER_SHIFT_EN
                ent_s <= c_data[0];
`endif
              end
              c_data[7:1] == 7'b0000001: begin
                ddram_addr <= '0;
                cnt        <= CLR_LD;
`ifdef LCD1604_RESPONDER_SHIFT_EN
                disp_shift <= '0;
`endif
              end
              c_data == 8'h01: begin
                cnt   <= CLR_LD;
                sweep <= '0;
`ifdef LCD1604_RESPONDER_SHIFT_EN
                disp_shift <= '0;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          if (cnt != '0) cnt <= cnt - 32'd1;
          if (sweep_last) begin
            sweep      <= '0;
            boot       <= 1'b0;
            ddram_addr <= '0;
            incr       <= 1'b1;
          end else begin
            sweep <= sweep + 7'd1;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) cnt <= cnt - 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_we = reset &&
    (state == ST_CLEAR || (state == ST_EXEC && c_rs));
  assign mem_wa = (state == ST_CLEAR) ? sweep
                                      : addr_index(ddram_addr);
  assign mem_wd = (state == ST_CLEAR) ? 8'h20 : c_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    dbg_char <= mem[addr_index(addr_fix(dbg_addr))];
  end

endmodule

// File: tb/tb_lcd1604_responder.sv
// Directed bench for lcd1604_responder: bus cycles, busy timing,
// address wrap and drop behaviour, with a read-data scoreboard.
module tb_lcd1604_responder;
  import lcd1604_pkg::*;

  localparam int BC    = 40;
  localparam int CC    = 150;
  localparam int LIMIT = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data_i, lcd_data_o;
  logic       lcd_data_oe, busy;
  logic       display_on, cursor_on, blink_on, incr;
  logic [6:0] ddram_addr, dbg_addr;
  logic       cmd_err;
  logic [7:0] dbg_char;
`ifdef LCD1604_RESPONDER_SHIFT_EN
  logic [5:0] disp_shift;
`endif

  int         checks   = 0;
  int         failures = 0;
  int         err_cnt  = 0;
  int         n;
  logic       b2, b3;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_err === 1'b1) err_cnt++;

  lcd1604_responder #(
    .BUSY_CYCLES  (BC),
    .CLEAR_CYCLES (CC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_e       (lcd_e),
    .lcd_data_i  (lcd_data_i),
    .lcd_data_o  (lcd_data_o),
    .lcd_data_oe (lcd_data_oe),
    .busy        (busy),
    .display_on  (display_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .incr        (incr),
    .ddram_addr  (ddram_addr),
    .cmd_err     (cmd_err),
    .dbg_addr    (dbg_addr),
    .dbg_char    (dbg_char)
`ifdef LCD1604_RESPONDER_SHIFT_EN
    ,
    .disp_shift  (disp_shift)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {24'd0, obs}, {24'd0, e});
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [6:0] a,
                         input logic [7:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    dbg_addr = a;
    @(posedge clk);
    @(negedge clk);
    pop_chk(dbg_char);
  endtask

  // One bus cycle; cyc counts clk edges from E falling until the
  // responder is idle again (or just 4 edges when not waiting).
  task automatic drive(input logic rs, input logic rw,
                       input logic [7:0] d, input bit wait_done,
                       output int cyc);
    @(negedge clk);
    lcd_rs     = rs;
    lcd_rw     = rw;
    lcd_data_i = d;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (8) @(negedge clk);
    if (rw) begin
      chk("read_oe_high", {31'd0, lcd_data_oe}, 32'd1);
      pop_chk(lcd_data_o);
    end
    lcd_e = 1'b0;
    cyc = 0;
    b2  = 1'b0;
    b3  = 1'b0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 2) b2 = busy;
      if (cyc == 3) b3 = busy;
    end while (cyc < LIMIT && (cyc < 4 || (wait_done && busy)));
    if (wait_done) chk("idle_timeout", {31'd0, cyc < LIMIT}, 32'd1);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d,
                    output int cyc);
    drive(rs, 1'b0, d, 1'b1, cyc);
  endtask

  task automatic rd(input string tag, input logic rs,
                    input logic [7:0] e);
    int c;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    drive(rs, 1'b1, 8'h00, 1'b1, c);
    chk({tag, "_oe_low"}, {31'd0, lcd_data_oe}, 32'd0);
  endtask

  task automatic boot_len(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (busy && cyc < LIMIT);
  endtask

  initial begin
    reset      = 1'b0;
    lcd_rs     = 1'b0;
    lcd_rw     = 1'b0;
    lcd_e      = 1'b0;
    lcd_data_i = 8'h00;
    dbg_addr   = 7'h00;
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_data_o", {24'd0, lcd_data_o}, 32'h00);
    chk("rst_oe", {31'd0, lcd_data_oe}, 32'd0);
    chk("rst_dcb", {29'd0, display_on, cursor_on, blink_on}, 32'd0);
    chk("rst_incr", {31'd0, incr}, 32'd1);
    chk("rst_addr", {25'd0, ddram_addr}, 32'd0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);

    reset = 1'b1;
    boot_len(n);
    chk("boot_busy_len", n, 32'd80);
    dbg_chk("boot_dbg_00", 7'h00, 8'h20);
    dbg_chk("boot_dbg_67", 7'h67, 8'h20);
    chk("boot_busy_low", {31'd0, busy}, 32'd0);

    wr(1'b0, CMD_FUNC, n);
    chk("func_busy_len", n, 32'(3 + BC));
    chk("busy_before_exec", {31'd0, b2}, 32'd0);
    chk("busy_in_exec", {31'd0, b3}, 32'd1);
    wr(1'b0, CMD_ENTRY, n);
    wr(1'b0, CMD_DISP_ON, n);
    wr(1'b0, CMD_CLEAR, n);
    chk("clear_busy_len", n, 32'(3 + CC));
    chk("init_dcb", {29'd0, display_on, cursor_on, blink_on}, 32'b100);
    chk("init_incr", {31'd0, incr}, 32'd1);
    chk("init_addr", {25'd0, ddram_addr}, 32'd0);
    chk("init_no_err", err_cnt, 32'd0);

    wr(1'b0, 8'hA7, n);
    wr(1'b1, 8'h41, n);
    wr(1'b1, 8'h42, n);
    dbg_chk("wrap_dbg_27", 7'h27, 8'h41);
    dbg_chk("wrap_dbg_40", LINE1_BASE, 8'h42);
    chk("wrap_addr", {25'd0, ddram_addr}, 32'h41);

    wr(1'b0, CMD_LINE2, n);
    chk("line2_addr", {25'd0, ddram_addr}, 32'h40);
    rd("data_read", 1'b1, 8'h42);
    chk("data_read_adv", {25'd0, ddram_addr}, 32'h41);
    rd("status_idle", 1'b0, 8'h41);

    wr(1'b0, 8'hFF, n);
    chk("fold_addr_ff", {25'd0, ddram_addr}, 32'h57);

    wr(1'b0, 8'h04, n);
    chk("entry_dec", {31'd0, incr}, 32'd0);
    wr(1'b0, 8'h80, n);
    wr(1'b1, 8'h5A, n);
    dbg_chk("dec_dbg_00", 7'h00, 8'h5A);
    chk("dec_wrap_addr", {25'd0, ddram_addr}, 32'h67);

    wr(1'b0, 8'h14, n);
    chk("cur_right_wrap", {25'd0, ddram_addr}, 32'h00);
    wr(1'b0, 8'h10, n);
    chk("cur_left_wrap", {25'd0, ddram_addr}, 32'h67);

    drive(1'b1, 1'b0, 8'h33, 1'b0, n);
    drive(1'b1, 1'b0, 8'h44, 1'b0, n);
    rd("status_busy", 1'b0, {1'b1, 7'h66});
    chk("drop_err_pulse", err_cnt, 32'd1);
    dbg_chk("drop_dbg_67", 7'h67, 8'h33);
    dbg_chk("drop_dbg_66", 7'h66, 8'h20);
    chk("drop_addr", {25'd0, ddram_addr}, 32'h66);

    wr(1'b0, 8'h02, n);
    chk("home_busy_len", n, 32'(3 + CC));
    chk("home_addr", {25'd0, ddram_addr}, 32'h00);

    wr(1'b0, CMD_CLEAR, n);
    chk("clear2_incr", {31'd0, incr}, 32'd1);
    dbg_chk("clear2_dbg_67", 7'h67, 8'h20);

    wr(1'b0, CMD_DISP_CUR, n);
    chk("disp_cur", {29'd0, display_on, cursor_on, blink_on}, 32'b110);

`ifdef LCD1604_RESPONDER_SHIFT_EN
    chk("shift_start", {26'd0, disp_shift}, 32'd0);
    wr(1'b0, 8'h18, n);
    chk("shift_left_wrap", {26'd0, disp_shift}, 32'd39);
    wr(1'b0, 8'h1C, n);
    chk("shift_right_wrap", {26'd0, disp_shift}, 32'd0);
    wr(1'b0, 8'h18, n);
    wr(1'b0, CMD_CLEAR, n);
    chk("shift_clear", {26'd0, disp_shift}, 32'd0);
`endif

    wr(1'b1, 8'h77, n);
    dbg_chk("pre_rst_dbg_00", 7'h00, 8'h77);
    drive(1'b0, 1'b0, 8'h0F, 1'b0, n);
    chk("pre_rst_blink", {31'd0, blink_on}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    boot_len(n);
    chk("midrst_busy_len", n, 32'd80);
    chk("midrst_dcb", {29'd0, display_on, cursor_on, blink_on}, 32'd0);
    chk("midrst_addr", {25'd0, ddram_addr}, 32'd0);
    dbg_chk("midrst_dbg_00", 7'h00, 8'h20);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
